// File: rtl/permute_pkg.sv
// ---------------------------------------------------------------------------
// permute_pkg
// Shared definitions for the permutation sequencer:
//   - default geometry (lanes per slice line, slice lines per round, rounds)
//   - fixed index port widths
//   - FSM state encoding
//   - saturating increment helper for the optional stall statistics
// ---------------------------------------------------------------------------
package permute_pkg;

    localparam int LANES_DEF  = 25;
    localparam int SLICES_DEF = 64;
    localparam int ROUNDS_DEF = 24;

    localparam int LANE_W  = 5;
    localparam int SLICE_W = 6;
    localparam int ROUND_W = 5;
    localparam int STALL_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [STALL_W-1:0] sat_inc(input logic [STALL_W-1:0] v);
        return (v == {STALL_W{1'b1}}) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/permute_ring_counter.sv
// ---------------------------------------------------------------------------
// permute_ring_counter
// Modulo-MODULUS counter with synchronous clear, count enable and carry-out.
// Ports:
//   clk      - clock, rising edge
//   rst      - asynchronous active-high reset (value -> 0)
//   i_clr    - synchronous clear to 0 (has priority over i_inc)
//   i_inc    - count enable
//   o_value  - current count, 0..MODULUS-1
//   o_carry  - i_inc while at MODULUS-1 (the wrap cycle), combinational
// ---------------------------------------------------------------------------
module permute_ring_counter #(
    parameter int MODULUS = 25,
    parameter int WIDTH   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_value,
    output logic             o_carry
);

    logic [WIDTH-1:0] r_value;
    logic             w_at_max;

    assign w_at_max = (r_value == WIDTH'(MODULUS - 1));
    assign o_carry  = i_inc & w_at_max;
    assign o_value  = r_value;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_value <= '0;
        end else if (i_clr) begin
            r_value <= '0;
        end else if (i_inc) begin
            r_value <= w_at_max ? '0 : r_value + WIDTH'(1);
        end
    end

endmodule

// File: rtl/permute_sequencer.sv
// ---------------------------------------------------------------------------
// permute_sequencer
// Walks a bit-serial permutation: LANES bits per slice line, SLICES lines per
// round, ROUNDS rounds. Each accepted upstream bit produces one en strobe and
// advances the lane/slice/round counters (three chained ring counters).
//
// Optional feature (macro PERMUTE_SEQ_STALL_STATS_EN): adds output stall_cnt,
// a saturating count of RUN cycles in which src_valid was low.
//
// Ports:
//   clk        - clock, rising edge
//   rst        - asynchronous active-high reset
//   start      - level-sampled run request, honoured only in IDLE
//   src_valid  - upstream bit available this cycle
//   en         - transfer strobe (RUN and src_valid)
//   lane_idx   - current lane     0..LANES-1
//   slice_idx  - current slice    0..SLICES-1
//   round_idx  - current round    0..ROUNDS-1
//   co_c25     - transfer on the last lane
//   co_c64     - transfer on the last slice line
//   busy       - high in RUN and DONE
//   done       - single-cycle completion pulse
//   stall_cnt  - (macro only) stalled RUN cycles, saturating
// ---------------------------------------------------------------------------
module permute_sequencer
    import permute_pkg::*;
#(
    parameter int LANES  = LANES_DEF,
    parameter int SLICES = SLICES_DEF,
    parameter int ROUNDS = ROUNDS_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               src_valid,
    output logic               en,
    output logic [LANE_W-1:0]  lane_idx,
    output logic [SLICE_W-1:0] slice_idx,
    output logic [ROUND_W-1:0] round_idx,
    output logic               co_c25,
    output logic               co_c64,
    output logic               busy,
    output logic               done
`ifdef PERMUTE_SEQ_STALL_STATS_EN
    ,
    output logic [STALL_W-1:0] stall_cnt
`endif
);

    state_t r_state;
    state_t w_state_next;

    logic w_en;
    logic w_clr;
    logic w_lane_carry;
    logic w_slice_carry;
    logic w_round_carry;

    assign w_en  = (r_state == ST_RUN) & src_valid;
    assign w_clr = (r_state == ST_IDLE) & start;

    assign en     = w_en;
    assign co_c25 = w_lane_carry;
    // Fires on every transfer of the last slice line, not only its wrap.
    assign co_c64 = w_en & (slice_idx == SLICE_W'(SLICES - 1));

    permute_ring_counter #(
        .MODULUS (LANES),
        .WIDTH   (LANE_W)
    ) u_lane_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_clr),
        .i_inc   (w_en),
        .o_value (lane_idx),
        .o_carry (w_lane_carry)
    );

    permute_ring_counter #(
        .MODULUS (SLICES),
        .WIDTH   (SLICE_W)
    ) u_slice_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_clr),
        .i_inc   (w_lane_carry),
        .o_value (slice_idx),
        .o_carry (w_slice_carry)
    );

    // Round carry is the final transfer of the permutation: last lane,
    // last slice line and last round all at once. All three counters wrap
    // to 0 on that transfer, which is the value they hold in IDLE.
    permute_ring_counter #(
        .MODULUS (ROUNDS),
        .WIDTH   (ROUND_W)
    ) u_round_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_clr),
        .i_inc   (w_slice_carry),
        .o_value (round_idx),
        .o_carry (w_round_carry)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                if (w_round_carry) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                busy         = 1'b1;
                done         = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

`ifdef PERMUTE_SEQ_STALL_STATS_EN
    logic [STALL_W-1:0] r_stall_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (w_clr) begin
            r_stall_cnt <= '0;
        end else if ((r_state == ST_RUN) && !src_valid) begin
            r_stall_cnt <= sat_inc(r_stall_cnt);
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: doc/permute_sequencer.md
PERMUTE_SEQUENCER -- requirements
Module: permute_sequencer

Interface
REQ-001 The module SHALL have parameter LANES, default 25, meaning bits per slice line.
REQ-002 The module SHALL have parameter SLICES, default 64, meaning slice lines per round.
REQ-003 The module SHALL have parameter ROUNDS, default 24, meaning rounds per permutation.
REQ-004 The module SHALL have port clk, input, 1 bit: single clock, all state on rising edge.
REQ-005 The module SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-006 The module SHALL have port start, input, 1 bit: request to begin one permutation.
REQ-007 The module SHALL have port src_valid, input, 1 bit: upstream bit available this cycle.
REQ-008 The module SHALL have port en, output, 1 bit: bit-transfer strobe to the datapath and file writer.
REQ-009 The module SHALL have port lane_idx, output, 5 bits: current lane, 0..LANES-1.
REQ-010 The module SHALL have port slice_idx, output, 6 bits: current slice, 0..SLICES-1.
REQ-011 The module SHALL have port round_idx, output, 5 bits: current round, 0..ROUNDS-1.
REQ-012 The module SHALL have port co_c25, output, 1 bit: last-lane carry-out.
REQ-013 The module SHALL have port co_c64, output, 1 bit: last-slice carry-out.
REQ-014 The module SHALL have port busy, output, 1 bit: high in RUN and DONE.
REQ-015 The module SHALL have port done, output, 1 bit: one-cycle completion pulse.

Function
REQ-016 The FSM SHALL have states IDLE, RUN and DONE.
REQ-017 In IDLE with start=1, the FSM SHALL go to RUN next edge and clear all counters to 0.
REQ-018 In RUN, en SHALL equal src_valid (combinational); src_valid=0 stalls, with all counters held.
REQ-019 Each en cycle SHALL increment lane_idx; at LANES-1, lane_idx wraps to 0 and slice_idx increments.
REQ-020 At slice_idx=SLICES-1 with a lane wrap, slice_idx SHALL wrap to 0 and round_idx increment.
REQ-021 co_c25 SHALL be en AND lane_idx==LANES-1; co_c64 SHALL be en AND slice_idx==SLICES-1 (both combinational).
REQ-022 A transfer with co_c25, co_c64 and round_idx==ROUNDS-1 SHALL move the FSM to DONE.
REQ-023 DONE SHALL last exactly one cycle with done=1, then return to IDLE; en=0 in DONE and IDLE.
REQ-024 start SHALL be ignored in RUN and DONE; start in IDLE is level-sampled.
REQ-025 Counters SHALL hold their final wrapped value (0) in IDLE until the next start.

Reset
REQ-026 On rst=1 the FSM SHALL enter IDLE immediately, including mid-RUN; the partial permutation is abandoned.
REQ-027 Reset values: lane_idx=0, slice_idx=0, round_idx=0, busy=0, done=0, en=0, co_c25=0, co_c64=0.

Configuration
REQ-028 With macro PERMUTE_SEQ_STALL_STATS_EN defined, the module SHALL add output stall_cnt, 16 bits.
REQ-029 stall_cnt SHALL count RUN cycles with src_valid=0, saturate at 16'hFFFF, clear on start in IDLE, and reset to 0.
REQ-030 Without the macro, the port and its counter SHALL be absent; all other behaviour is unchanged.

Structure
REQ-031 The state encoding and the LANES/SLICES/ROUNDS defaults SHALL live in shared package permute_pkg.
REQ-032 One sub-module, permute_ring_counter (parameterised modulo counter with enable and carry-out), SHALL be instantiated three times.

Verification
REQ-033 ROUNDS=1, start pulse at cycle 0, src_valid=1 constant -> en high cycles 1..1600, co_c25 on every 25th transfer (64 total), co_c64 25 times, done=1 at cycle 1601, busy=0 at cycle 1602.
REQ-034 src_valid low for 10 cycles at transfer 30 -> counters frozen (lane 4, slice 1), done 10 cycles later than REQ-033; stall_cnt=10 with the macro.
REQ-035 rst asserted at transfer 800 -> all outputs 0 the same cycle; a new start completes a full 1600-transfer run.
REQ-036 start held high through RUN and DONE -> no restart mid-run; a new run begins the cycle after DONE.
REQ-037 ROUNDS=24, src_valid=1 -> round_idx increments every 1600 transfers, done after 38400 transfers.
REQ-038 With the macro, src_valid=0 for 70000 RUN cycles -> stall_cnt holds 65535.
